// File: rtl/mem_arbiter.sv
// Three-port memory arbiter: data-cache fill, instruction-cache fill and store-buffer drain
// share one memory port with a single outstanding transaction and store-starvation override.
module mem_arbiter #(
  parameter int unsigned ARCH_BITS    = 32,
  parameter int unsigned LINE_BITS    = 128,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iReq,
  input  logic [ARCH_BITS-1:0] iAddr,
  output logic [LINE_BITS-1:0] iData,
  output logic                 iAck,
  input  logic                 dReq,
  input  logic [ARCH_BITS-1:0] dAddr,
  output logic [LINE_BITS-1:0] dData,
  output logic                 dAck,
  input  logic                 sReq,
  input  logic [ARCH_BITS-1:0] sAddr,
  input  logic [LINE_BITS-1:0] sData,
  output logic                 sAck,
  output logic                 memReq,
  output logic                 memWe,
  output logic [ARCH_BITS-1:0] memAddr,
  output logic [LINE_BITS-1:0] memWData,
  input  logic [LINE_BITS-1:0] memRData,
  input  logic                 memAck
);

  localparam int unsigned CNT_BITS = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {PORT_I, PORT_D, PORT_S} port_t;

  state_t              state;
  port_t               port;
  logic [CNT_BITS-1:0] starve;
  logic                store_wins_c;

  // Store wins when it is alone or has lost STARVE_LIMIT arbitrations in a row.
  assign store_wins_c = sReq && ((starve == CNT_BITS'(STARVE_LIMIT)) || (!dReq && !iReq));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      port     <= PORT_D;
      starve   <= '0;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWData <= '0;
      iData    <= '0;
      dData    <= '0;
      iAck     <= 1'b0;
      dAck     <= 1'b0;
      sAck     <= 1'b0;
    end else begin
      iAck <= 1'b0;
      dAck <= 1'b0;
      sAck <= 1'b0;
      case (state)
        IDLE: begin
          if (iReq || dReq || sReq) begin
            state  <= BUSY;
            memReq <= 1'b1;
            if (store_wins_c) begin
              port     <= PORT_S;
              memAddr  <= sAddr;
              memWData <= sData;
              memWe    <= 1'b1;
              starve   <= '0;
            end else begin
              port    <= dReq ? PORT_D : PORT_I;
              memAddr <= dReq ? dAddr : iAddr;
              memWe   <= 1'b0;
              if (sReq && (starve != {CNT_BITS{1'b1}})) starve <= starve + CNT_BITS'(1);
            end
          end
        end
        BUSY: begin
          // Latched request stays on the bus until memory completes it.
          if (memAck) begin
            state  <= DONE;
            memReq <= 1'b0;
            memWe  <= 1'b0;
            case (port)
              PORT_I: begin
                iData <= memRData;
                iAck  <= 1'b1;
              end
              PORT_D: begin
                dData <= memRData;
                dAck  <= 1'b1;
              end
              default: sAck <= 1'b1;
            endcase
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A withdrawn store request forgets its lost arbitrations.
      if (!sReq) starve <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level priority/starvation model.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;
  localparam int unsigned SL = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          iReq, dReq, sReq;
  logic [AW-1:0] iAddr, dAddr, sAddr;
  logic [LW-1:0] sData, iData, dData;
  logic          iAck, dAck, sAck;
  logic          memReq, memWe, memAck;
  logic [AW-1:0] memAddr;
  logic [LW-1:0] memWData, memRData;

  int            n_vec = 0;
  int            n_err = 0;
  int            losses;
  logic [LW-1:0] exp_i, exp_d;

  mem_arbiter #(.ARCH_BITS(AW), .LINE_BITS(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iData(iData), .iAck(iAck),
    .dReq(dReq), .dAddr(dAddr), .dData(dData), .dAck(dAck),
    .sReq(sReq), .sAddr(sAddr), .sData(sData), .sAck(sAck),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference winner: 0 = icache, 1 = dcache, 2 = store buffer.
  function automatic int pick();
    if (sReq && losses == int'(SL)) return 2;
    if (dReq) return 1;
    if (iReq) return 0;
    return 2;
  endfunction

  // Serve one transaction from an IDLE cycle with the currently driven requests.
  task automatic do_txn(input int lat, input logic [LW-1:0] rd, input bit reassert_d,
                        input bit ack_high, output logic got_we);
    int            w;
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd;
    w   = pick();
    if (sReq) losses = (w == 2) ? 0 : ((losses < 15) ? losses + 1 : 15);
    else losses = 0;
    ea  = (w == 0) ? iAddr : (w == 1) ? dAddr : sAddr;
    ewd = sData;
    step();
    got_we = memWe;
    n_vec++;
    if (memReq !== 1'b1 || memAddr !== ea || memWe !== (w == 2)) begin
      n_err++;
      $display("FAIL grant: memReq=%b memAddr=%h memWe=%b, expected 1 %h %b",
               memReq, memAddr, memWe, ea, w == 2);
    end
    if (w == 2) begin
      n_vec++;
      if (memWData !== ewd) begin
        n_err++;
        $display("FAIL store_wdata: got %h expected %h", memWData, ewd);
      end
    end
    for (int j = 0; j < lat; j++) begin
      if (w == 0) iAddr = AW'($urandom);
      else if (w == 1) dAddr = AW'($urandom);
      else sAddr = AW'($urandom);
      memRData = rnd_line();
      step();
      n_vec++;
      if (memReq !== 1'b1 || memAddr !== ea || memWe !== (w == 2) || iAck || dAck || sAck) begin
        n_err++;
        $display("FAIL busy_hold: memReq=%b memAddr=%h memWe=%b acks=%b%b%b, expected 1 %h %b 000",
                 memReq, memAddr, memWe, iAck, dAck, sAck, ea, w == 2);
      end
    end
    memRData = rd;
    memAck   = 1'b1;
    step();
    if (!ack_high) memAck = 1'b0;
    if (w == 0) exp_i = rd;
    if (w == 1) exp_d = rd;
    n_vec++;
    if (iAck !== (w == 0) || dAck !== (w == 1) || sAck !== (w == 2) || memReq !== 1'b0 ||
        iData !== exp_i || dData !== exp_d) begin
      n_err++;
      $display("FAIL ack: acks i/d/s=%b%b%b memReq=%b iData=%h dData=%h, expected %b%b%b 0 %h %h",
               iAck, dAck, sAck, memReq, iData, dData, w == 0, w == 1, w == 2, exp_i, exp_d);
    end
    if (w == 0) iReq = 1'b0;
    if (w == 1) dReq = reassert_d;
    if (w == 2) sReq = 1'b0;
    step();
    n_vec++;
    if (iAck || dAck || sAck || memReq !== 1'b0) begin
      n_err++;
      $display("FAIL ack_pulse: acks i/d/s=%b%b%b memReq=%b, expected 000 0",
               iAck, dAck, sAck, memReq);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    iReq = 0; dReq = 0; sReq = 0; memAck = 0;
    step();
    step();
    rst = 1'b0;
    losses = 0;
    exp_i  = '0;
    exp_d  = '0;
  endtask

  task automatic test_reset();
    iAddr = '1; dAddr = '1; sAddr = '1; sData = '1; memRData = '1;
    apply_reset();
    n_vec++;
    if (memReq || memWe || iAck || dAck || sAck || memAddr !== '0 || memWData !== '0 ||
        iData !== '0 || dData !== '0) begin
      n_err++;
      $display("FAIL reset: memReq=%b memWe=%b acks=%b%b%b memAddr=%h memWData=%h iData=%h dData=%h, expected all 0",
               memReq, memWe, iAck, dAck, sAck, memAddr, memWData, iData, dData);
    end
  endtask

  task automatic test_single_read();
    logic we;
    dAddr = AW'(32'h100);
    dReq  = 1'b1;
    do_txn(3, {16{8'hA5}}, 1'b0, 1'b0, we);
    n_vec++;
    if (dData !== {16{8'hA5}}) begin
      n_err++;
      $display("FAIL single_read_data: got %h expected %h", dData, {16{8'hA5}});
    end
  endtask

  task automatic test_priority();
    logic we;
    iAddr = AW'(32'h1000); dAddr = AW'(32'h2000); sAddr = AW'(32'h3000); sData = rnd_line();
    iReq = 1; dReq = 1; sReq = 1;
    for (int k = 0; k < 3; k++) do_txn(int'($urandom_range(0, 2)), rnd_line(), 1'b0, 1'b0, we);
    n_vec++;
    if (memReq !== 1'b0 || iAck || dAck || sAck) begin
      n_err++;
      $display("FAIL priority_drain: memReq=%b acks=%b%b%b, expected 0 000", memReq, iAck, dAck, sAck);
    end
  endtask

  task automatic test_starve();
    logic we;
    apply_reset();
    sAddr = AW'(32'h5500); sData = rnd_line();
    dAddr = AW'(32'h6600);
    sReq = 1; dReq = 1;
    for (int k = 0; k <= int'(SL); k++) begin
      do_txn(int'($urandom_range(0, 1)), rnd_line(), 1'b1, 1'b0, we);
      n_vec++;
      if (we !== (k == int'(SL))) begin
        n_err++;
        $display("FAIL starve_grant%0d: memWe=%b expected %b", k, we, k == int'(SL));
      end
    end
    dReq = 0;
  endtask

  task automatic test_ack_tied_high();
    logic we;
    memAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iReq = 1; iAddr = AW'($urandom);
      do_txn(0, rnd_line(), 1'b0, 1'b1, we);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (iAck || dAck || sAck || memReq) begin
        n_err++;
        $display("FAIL stray_ack: acks=%b%b%b memReq=%b, expected 000 0", iAck, dAck, sAck, memReq);
      end
    end
    memAck = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic we;
    dAddr = AW'(32'h200);
    dReq  = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    n_vec++;
    if (memReq !== 1'b0 || dAck !== 1'b0 || dData !== '0) begin
      n_err++;
      $display("FAIL reset_abort: memReq=%b dAck=%b dData=%h, expected 0 0 0", memReq, dAck, dData);
    end
    rst = 1'b0;
    losses = 0; exp_i = '0; exp_d = '0;
    do_txn(2, rnd_line(), 1'b0, 1'b0, we);
  endtask

  task automatic test_random();
    logic we;
    for (int n = 0; n < 60; n++) begin
      if (!iReq && $urandom_range(0, 1) == 1) begin iReq = 1; iAddr = AW'($urandom); end
      if (!dReq && $urandom_range(0, 2) == 0) begin dReq = 1; dAddr = AW'($urandom); end
      if (!sReq && $urandom_range(0, 1) == 1) begin
        sReq = 1; sAddr = AW'($urandom); sData = rnd_line();
      end
      if (!iReq && !dReq && !sReq) begin dReq = 1; dAddr = AW'($urandom); end
      do_txn(int'($urandom_range(0, 3)), rnd_line(), $urandom_range(0, 3) != 0, 1'b0, we);
    end
    iReq = 0; dReq = 0; sReq = 0;
  endtask

  initial begin
    rst = 1'b1;
    iReq = 0; dReq = 0; sReq = 0; memAck = 0;
    iAddr = '0; dAddr = '0; sAddr = '0; sData = '0; memRData = '0;
    test_reset();
    test_single_read();
    test_priority();
    test_starve();
    test_ack_tied_high();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ARCH_BITS, default 32, address width.
REQ-002 SHALL have parameter LINE_BITS, default 128, memory line width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, lost arbitrations before forced store-buffer grant (1..15).
REQ-004 clk  in  1  clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 iReq / iAddr  in  1 / ARCH_BITS  instruction-cache line-fill request and address.
REQ-007 iData / iAck  out  LINE_BITS / 1  fill data; one-cycle completion pulse.
REQ-008 dReq / dAddr  in  1 / ARCH_BITS  data-cache line-fill request and address.
REQ-009 dData / dAck  out  LINE_BITS / 1  fill data; one-cycle completion pulse.
REQ-010 sReq / sAddr / sData  in  1 / ARCH_BITS / LINE_BITS  store-buffer drain (write) request, address, line.
REQ-011 sAck  out  1  one-cycle write-completion pulse.
REQ-012 memReq / memWe  out  1 / 1  memory request; 1 = write, 0 = read.
REQ-013 memAddr / memWData  out  ARCH_BITS / LINE_BITS  memory address and write line.
REQ-014 memRData / memAck  in  LINE_BITS / 1  read line; completion, valid only while memReq=1.

Function
REQ-015 SHALL implement FSM IDLE, BUSY, DONE; exactly one memory transaction outstanding.
REQ-016 In IDLE with any req high, SHALL pick a winner, latch port id, address, write line (store only), enter BUSY next edge.
REQ-017 Priority: dReq > iReq > sReq, unless starve counter == STARVE_LIMIT and sReq=1, then store wins.
REQ-018 Starve counter: 4-bit saturating; +1 per IDLE arbitration where sReq=1 and store loses; cleared on store grant or any cycle with sReq=0.
REQ-019 In BUSY, memReq=1 and memAddr/memWe/memWData driven from latched values, stable until memAck.
REQ-020 On memAck in BUSY, SHALL latch memRData into winner's data register (reads only), enter DONE.
REQ-021 In DONE, SHALL pulse exactly the winner's ack for one cycle, memReq=0, then return to IDLE.
REQ-022 Latency: req seen in IDLE at cycle 0 -> memReq from cycle 1 -> memAck at cycle k (k>=1) -> ack at cycle k+1; minimum 2 cycles req-to-ack.
REQ-023 Requester SHALL hold req and inputs until its ack; it drops req the cycle after ack; arbiter ignores req/input changes outside IDLE.
REQ-024 A req still high in the IDLE cycle after DONE SHALL be a new request (back-to-back allowed, one IDLE cycle between transactions).
REQ-025 iData/dData SHALL hold last fetched line until next fill on that port; store never alters them.
REQ-026 memAck while not BUSY SHALL be ignored.
REQ-027 Simultaneous requests: losers keep waiting, no ack, no data change.

Reset
REQ-028 On rst: state IDLE, starve counter 0, memReq/memWe/iAck/dAck/sAck 0, memAddr/memWData/iData/dData 0.
REQ-029 rst in BUSY or DONE SHALL abort the transaction: memReq low next cycle, no ack issued; requester reissues.

Verification
REQ-030 dReq only, dAddr=0x100, memAck 3 cycles after memReq, memRData=0xA5..A5 -> dAck single pulse, dData=0xA5..A5, memWe=0 throughout.
REQ-031 iReq, dReq, sReq together -> order d, i, s; memAddr matches each; exactly one ack per transaction, one IDLE cycle between.
REQ-032 sReq held, dReq re-asserted continuously, STARVE_LIMIT=8 -> store granted at 9th arbitration, memWe=1, memWData=sData, sAck pulses.
REQ-033 memAck tied high -> each transaction req-to-ack in 2 cycles; stray memAck in IDLE causes no ack.
REQ-034 rst asserted while BUSY with dReq -> memReq 0 next cycle, no dAck, dData=0; after release, dReq re-served normally.
REQ-035 dAddr changed while BUSY -> memAddr stays at originally latched address until memAck.
